// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the SARM pipeline hazard/forwarding controller.
package pipeline_ctrl_pkg;

  // Register addresses are zero-extended into slots of this width.
  localparam int unsigned DEST_W = 8;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef struct packed {
    logic              valid;
    logic              wb_en;
    logic              mem_r_en;
    logic              mem_w_en;
    logic [DEST_W-1:0] dest;
  } slot_t;

  typedef struct packed {
    slot_t             s;
    logic [DEST_W-1:0] src1;
    logic [DEST_W-1:0] src2;
    logic              two_src;
  } ex_slot_t;

  localparam slot_t    BUBBLE    = '0;
  localparam ex_slot_t EX_BUBBLE = '0;

  // A load in MEM has no result yet, so it falls through to the WB check.
  function automatic logic [1:0] fwd_pick(input logic fwd_en, input logic hit_mem,
                                          input logic mem_is_load, input logic hit_wb);
    if (!fwd_en)                   return FWD_REG;
    if (hit_mem && !mem_is_load)   return FWD_MEM;
    if (hit_wb)                    return FWD_WB;
    return FWD_REG;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_src_match.sv
// Compares one source register against one scoreboard slot's pending write.
module src_match
  import pipeline_ctrl_pkg::*;
(
  input  slot_t             i_slot,
  input  logic [DEST_W-1:0] i_src,
  output logic              o_match
);

  logic w_unused_bits;

  assign o_match       = i_slot.valid & i_slot.wb_en & (i_slot.dest == i_src);
  assign w_unused_bits = i_slot.mem_r_en ^ i_slot.mem_w_en;

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard, forwarding, flush and memory-freeze controller with EX/MEM/WB shadow scoreboard.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_fwd_en,
  input  logic                  i_id_valid,
  input  logic [REG_ADDR_W-1:0] i_id_src1,
  input  logic [REG_ADDR_W-1:0] i_id_src2,
  input  logic                  i_id_two_src,
  input  logic                  i_id_wb_en,
  input  logic                  i_id_mem_r_en,
  input  logic                  i_id_mem_w_en,
  input  logic [REG_ADDR_W-1:0] i_id_dest,
  input  logic                  i_exe_branch_taken,
  input  logic                  i_mem_ready,
  output logic                  o_freeze_front,
  output logic                  o_flush_if,
  output logic                  o_bubble_ex,
  output logic                  o_freeze_all,
  output logic [1:0]            o_sel_src1,
  output logic [1:0]            o_sel_src2,
  output logic [CNT_W-1:0]      o_hazard_cnt,
  output logic [CNT_W-1:0]      o_mem_wait_cnt,
  output logic [CNT_W-1:0]      o_flush_cnt
);

  ex_slot_t r_ex;
  slot_t    r_mem;
  slot_t    r_wb;

  logic [CNT_W-1:0] r_hazard_cnt;
  logic [CNT_W-1:0] r_mem_wait_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic [DEST_W-1:0] w_id_src1;
  logic [DEST_W-1:0] w_id_src2;
  logic w_id1_ex, w_id1_mem, w_id2_ex, w_id2_mem;
  logic w_ex1_mem, w_ex1_wb, w_ex2_mem, w_ex2_wb;
  logic w_id_hit_ex, w_id_hit_mem;
  logic w_hazard;
  logic w_mem_busy;
  ex_slot_t w_ex_next;

  assign w_id_src1 = DEST_W'(i_id_src1);
  assign w_id_src2 = DEST_W'(i_id_src2);

  src_match u_id1_ex  (.i_slot(r_ex.s), .i_src(w_id_src1), .o_match(w_id1_ex));
  src_match u_id1_mem (.i_slot(r_mem),  .i_src(w_id_src1), .o_match(w_id1_mem));
  src_match u_id2_ex  (.i_slot(r_ex.s), .i_src(w_id_src2), .o_match(w_id2_ex));
  src_match u_id2_mem (.i_slot(r_mem),  .i_src(w_id_src2), .o_match(w_id2_mem));
  src_match u_ex1_mem (.i_slot(r_mem),  .i_src(r_ex.src1), .o_match(w_ex1_mem));
  src_match u_ex1_wb  (.i_slot(r_wb),   .i_src(r_ex.src1), .o_match(w_ex1_wb));
  src_match u_ex2_mem (.i_slot(r_mem),  .i_src(r_ex.src2), .o_match(w_ex2_mem));
  src_match u_ex2_wb  (.i_slot(r_wb),   .i_src(r_ex.src2), .o_match(w_ex2_wb));

  assign w_id_hit_ex  = w_id1_ex  | (i_id_two_src & w_id2_ex);
  assign w_id_hit_mem = w_id1_mem | (i_id_two_src & w_id2_mem);

  // With forwarding only a load in EX cannot be bypassed in time.
  assign w_hazard = i_id_valid & (i_fwd_en ? (w_id_hit_ex & r_ex.s.mem_r_en)
                                           : (w_id_hit_ex | w_id_hit_mem));

  assign w_mem_busy = r_mem.valid & (r_mem.mem_r_en | r_mem.mem_w_en) & ~i_mem_ready;

  assign o_freeze_all   = w_mem_busy;
  assign o_flush_if     = i_exe_branch_taken & ~w_mem_busy;
  assign o_freeze_front = w_hazard & ~i_exe_branch_taken & ~w_mem_busy;
  assign o_bubble_ex    = (w_hazard | i_exe_branch_taken) & ~w_mem_busy;

  assign o_sel_src1 = fwd_pick(i_fwd_en, w_ex1_mem, r_mem.mem_r_en, w_ex1_wb);
  assign o_sel_src2 = r_ex.two_src ? fwd_pick(i_fwd_en, w_ex2_mem, r_mem.mem_r_en, w_ex2_wb)
                                   : FWD_REG;

  always_comb begin
    w_ex_next = EX_BUBBLE;
    if (!o_bubble_ex && i_id_valid) begin
      w_ex_next.s.valid    = 1'b1;
      w_ex_next.s.wb_en    = i_id_wb_en;
      w_ex_next.s.mem_r_en = i_id_mem_r_en;
      w_ex_next.s.mem_w_en = i_id_mem_w_en;
      w_ex_next.s.dest     = DEST_W'(i_id_dest);
      w_ex_next.src1       = w_id_src1;
      w_ex_next.src2       = w_id_src2;
      w_ex_next.two_src    = i_id_two_src;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex  <= EX_BUBBLE;
      r_mem <= BUBBLE;
      r_wb  <= BUBBLE;
    end else if (!w_mem_busy) begin
      r_wb  <= r_mem;
      r_mem <= r_ex.s;
      r_ex  <= w_ex_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hazard_cnt   <= '0;
      r_mem_wait_cnt <= '0;
      r_flush_cnt    <= '0;
    end else begin
      if (o_freeze_front && r_hazard_cnt != '1)
        r_hazard_cnt <= r_hazard_cnt + CNT_W'(1);
      if (o_freeze_all && r_mem_wait_cnt != '1)
        r_mem_wait_cnt <= r_mem_wait_cnt + CNT_W'(1);
      if (o_flush_if && r_flush_cnt != '1)
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign o_hazard_cnt   = r_hazard_cnt;
  assign o_mem_wait_cnt = r_mem_wait_cnt;
  assign o_flush_cnt    = r_flush_cnt;

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Parametrised hazard, forwarding and stall controller for the 5-stage SARM pipeline. It folds hazard detection, forwarding select, branch flush and memory wait-state freeze into one sequential block. It keeps its own shadow scoreboard of the EXE, MEM and WB slots, so the core top only feeds it ID-stage decode, the EXE branch outcome and the memory ready handshake. Forwarding is selected at run time (`fwd_en`). Stall, wait and flush events are counted for performance analysis.

## Interface
- REG_ADDR_W, 4: register-address width (16 architectural registers).
- CNT_W, 16: width of each saturating event counter.

- clk  in  1  pipeline clock.
- rst  in  1  reset; one clock, asynchronous and active-high.
- fwd_en  in  1  1 = forwarding mode, 0 = stall-only mode.
- id_valid  in  1  ID holds a real instruction.
- id_src1, id_src2  in  REG_ADDR_W  ID source registers.
- id_two_src  in  1  id_src2 is a real operand.
- id_wb_en, id_mem_r_en, id_mem_w_en  in  1  ID control bits.
- id_dest  in  REG_ADDR_W  ID destination register.
- exe_branch_taken  in  1  the instruction in EXE is a taken branch.
- mem_ready  in  1  memory finished the access in the MEM slot.
- freeze_front  out  1  hold PC and IF/ID.
- flush_if  out  1  clear IF/ID.
- bubble_ex  out  1  load a bubble into ID/EX.
- freeze_all  out  1  hold every pipeline register.
- sel_src1, sel_src2  out  2  EXE operand select: 00 register file, 01 MEM-slot ALU result, 10 WB result.
- hazard_cnt, mem_wait_cnt, flush_cnt  out  CNT_W  event counters.

## Operation
- **Scoreboard.** Three slots: EX, MEM, WB.
  - Each slot holds `valid`, `wb_en`, `mem_r_en`, `mem_w_en` and `dest`.
  - The EX slot also holds `src1`, `src2` and `two_src`.
- **Memory wait.** `mem_busy = MEM.valid & (MEM.mem_r_en | MEM.mem_w_en) & !mem_ready`. `freeze_all = mem_busy`.
- **Source match.** A source matches a slot when `slot.valid & slot.wb_en & slot.dest == src`. src2 is considered only when `id_two_src` is 1.
- **Hazard, fwd_en=0.** `hazard = id_valid & (match against EX or MEM)`. WB is never checked, because the register file writes before read.
- **Hazard, fwd_en=1.** `hazard = id_valid & match against EX & EX.mem_r_en` (load-use only).
- **Branch priority.** A taken branch overrides hazard, since the stalled instruction is wrong-path.
  - `flush_if = exe_branch_taken & !freeze_all`.
  - `freeze_front = hazard & !exe_branch_taken & !freeze_all`.
  - `bubble_ex = (hazard | exe_branch_taken) & !freeze_all`.
  - During freeze_all, flush_if, freeze_front and bubble_ex are all 0.
- **Forwarding select.** Evaluated for the EX-slot sources; applies only when `fwd_en=1`, otherwise 00.
  - Select 01 if the source matches MEM and MEM is not a load.
  - Otherwise select 10 if the source matches WB.
  - MEM has priority over WB.
  - sel_src2 is 00 when `EX.two_src=0`.
- **Slot update.** On a clock edge with `freeze_all=0`:
  - WB ← MEM, MEM ← EX.
  - EX ← bubble (all bits 0) if `bubble_ex | !id_valid`; otherwise EX ← ID fields.
  - With `freeze_all=1`, all slots hold.
- **Counters.** All saturate at all-ones.
  - hazard_cnt +1 per cycle with `freeze_front=1`.
  - mem_wait_cnt +1 per cycle with `freeze_all=1`.
  - flush_cnt +1 per cycle with `flush_if=1`.

## Timing
- **Reset.** All slots invalid with fields 0; counters 0. Consequently every output is 0 (sel 00), except where mem_ready and the ID inputs drive combinational outputs. With slots empty these are 0 as well.
- **Output paths.** All control outputs are combinational from the slots and the current inputs, with zero cycles of latency. They are valid before the next edge.
- **Load-use.** Exactly 1 stall cycle (bubble), then forwarding from WB.
- **Branch.** A taken branch in EXE at cycle t removes the two younger instructions. The EX slot holds a bubble at t+1.
- **Simultaneous branch and freeze_all.** The flush is deferred until the first cycle with `freeze_all=0`, because exe_branch_taken is held by the frozen ID/EX register.
- **Mid-operation reset.** rst asserted at any cycle clears the slots and counters immediately. No partial state survives.

## Structure
- **Package `pipeline_ctrl_pkg`:**
  - FWD_REG=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10.
  - `slot_t` struct (valid, wb_en, mem_r_en, mem_w_en, dest).
  - `BUBBLE` constant.
- **Sub-module `src_match`:** combinational comparator of one source against one slot. Instantiated per source and per slot.

## Test plan
- **Stall-only RAW.** fwd_en=0; `ADD R1` then `SUB R2,R1,R3` → freeze_front=1 for 2 cycles; hazard_cnt=2; sel stays 00.
- **Forwarding RAW.** fwd_en=1, same pair → no stall. sel_src1=01 when SUB is in EXE. A third dependent instruction two behind gets sel_src1=10.
- **Load-use.** fwd_en=1; `LDR R4` then `ADD R5,R4,#1` → exactly 1 stall cycle and bubble_ex=1 in that cycle, then sel_src1=10.
- **Branch vs hazard.** exe_branch_taken=1 while ID has a hazard → flush_if=1, bubble_ex=1, freeze_front=0; flush_cnt=1.
- **Memory wait.** MEM holds an LDR and mem_ready=0 for 3 cycles → freeze_all=1 for 3 cycles; slots unchanged; mem_wait_cnt=3. A branch taken during the wait flushes on the first released cycle.
- **Reset and saturation.** rst asserted mid-stall → all outputs 0 next sample. With CNT_W=2, 5 stalls → hazard_cnt=3.
